// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// State encodings are fixed so the CU bench can decode the controller's state.
package mem_access_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CU-side request/response signals plus the RAM-side port of the access controller.
// The slave view belongs to the controller; the master view drives requests and models the RAM.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_inac;
    logic [DATA_W-1:0] data_out;
    logic              rd_zero;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  read_req, write_req, addr_in, data_inac, mem_rdata,
        output data_out, rd_zero, busy, done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output read_req, write_req, addr_in, data_inac, mem_rdata,
        input  data_out, rd_zero, busy, done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory responder: one CU read or write at a time, hiding the RAM read
// latency behind busy/done. Every output comes straight from a register.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);

    localparam int              LAT_W    = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    state_e             state_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic               wr_op_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               rd_zero_q;
    logic               busy_q;
    logic               done_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
            wr_op_q     <= 1'b0;
            data_out_q  <= '0;
            rd_zero_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Write has priority when both requests arrive together.
                    if (bus.write_req || bus.read_req) begin
                        mem_addr_q  <= bus.addr_in;
                        mem_wdata_q <= bus.data_inac;
                        wr_op_q     <= bus.write_req;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.write_req;
                        busy_q      <= 1'b1;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (wr_op_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        data_out_q <= bus.mem_rdata;
                        rd_zero_q  <= (bus.mem_rdata == '0);
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.rd_zero   = rd_zero_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a behavioural RAM
// and a word-level memory/data_out model.
module tb_mem_access_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: read data appears RD_LAT edges after mem_en is sampled,
    // for one cycle only; other cycles show a poison word.
    logic [DATA_W-1:0] ram_mem [0:255];
    logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int ri = 0; ri < 256; ri++) ram_mem[ri] <= '0;
        end else if (bus.mem_en && bus.mem_we) begin
            ram_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram_mem[bus.mem_addr[7:0]] : 16'hDEAD;
        for (int pi = 1; pi < RD_LAT; pi++) rd_pipe[pi] <= rd_pipe[pi-1];
    end

    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    int done_cnt = 0;
    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference model: memory contents and the word data_out should hold.
    logic [DATA_W-1:0] model_mem [0:255];
    logic [DATA_W-1:0] exp_dout;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic both);
        int d0;
        d0 = done_cnt;
        bus.write_req = 1'b1;
        bus.read_req  = both;
        bus.addr_in   = a;
        bus.data_inac = d;
        tick();
        check("wr_mem_en", 32'(bus.mem_en), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'(a));
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'(d));
        check("wr_busy", 32'(bus.busy), 32'd1);
        bus.write_req = 1'b0;
        bus.read_req  = 1'b0;
        bus.addr_in   = ADDR_W'($urandom);
        bus.data_inac = DATA_W'($urandom);
        tick();
        model_mem[a[7:0]] = d;
        check("wr_done", 32'(bus.done), 32'd1);
        check("wr_busy_done", 32'(bus.busy), 32'd0);
        check("wr_mem_we_off", 32'(bus.mem_we), 32'd0);
        check("wr_addr_hold", 32'(bus.mem_addr), 32'(a));
        check("wr_dout_kept", 32'(bus.data_out), 32'(exp_dout));
        tick();
        check("wr_done_once", 32'(done_cnt - d0), 32'd1);
        check("wr_done_low", 32'(bus.done), 32'd0);
        $display("write addr=%04h data=%04h both=%0d", a, d, both);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic pulse);
        logic [DATA_W-1:0] exp;
        int d0;
        d0 = done_cnt;
        exp = model_mem[a[7:0]];
        bus.read_req = 1'b1;
        bus.addr_in  = a;
        tick();
        check("rd_mem_en", 32'(bus.mem_en), 32'd1);
        check("rd_mem_we", 32'(bus.mem_we), 32'd0);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'(a));
        check("rd_busy_acc", 32'(bus.busy), 32'd1);
        for (int k = 0; k < RD_LAT; k++) begin
            bus.read_req = pulse;
            bus.addr_in  = ADDR_W'($urandom);
            tick();
            check("rd_busy_wait", 32'(bus.busy), 32'd1);
            check("rd_done_wait", 32'(bus.done), 32'd0);
            check("rd_mem_en_wait", 32'(bus.mem_en), 32'd0);
            check("rd_dout_hold", 32'(bus.data_out), 32'(exp_dout));
        end
        tick();
        exp_dout = exp;
        check("rd_done", 32'(bus.done), 32'd1);
        check("rd_busy_done", 32'(bus.busy), 32'd0);
        check("rd_data", 32'(bus.data_out), 32'(exp));
        check("rd_zero", 32'(bus.rd_zero), 32'(exp == '0));
        bus.read_req = 1'b0;
        tick();
        check("rd_idle_busy", 32'(bus.busy), 32'd0);
        check("rd_idle_en", 32'(bus.mem_en), 32'd0);
        check("rd_done_once", 32'(done_cnt - d0), 32'd1);
        $display("read addr=%04h data=%04h pulse=%0d", a, bus.data_out, pulse);
    endtask

    initial begin
        bus.read_req  = 1'b0;
        bus.write_req = 1'b0;
        bus.addr_in   = '0;
        bus.data_inac = '0;
        for (int mi = 0; mi < 256; mi++) model_mem[mi] = '0;
        exp_dout = '0;
        rst = 1'b1;
        ram_clr = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ram_clr = 1'b0;
        repeat (3) tick();
        check("rst_dout", 32'(bus.data_out), 32'd0);
        check("rst_zero", 32'(bus.rd_zero), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        $display("reset idle checked");

        do_write(16'h0010, 16'd16, 1'b0);
        do_read(16'h0010, 1'b0);
        do_write(16'h0020, 16'd32, 1'b1);
        check("both_no_read", 32'(bus.data_out), 32'd16);
        do_read(16'h0020, 1'b0);
        do_read(16'h0030, 1'b1);

        // Reset during RD_WAIT: abandoned read, no done, no late capture.
        begin
            int d0;
            d0 = done_cnt;
            bus.read_req = 1'b1;
            bus.addr_in  = 16'h0010;
            tick();
            bus.read_req = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_dout = '0;
            check("mid_rst_busy", 32'(bus.busy), 32'd0);
            check("mid_rst_dout", 32'(bus.data_out), 32'd0);
            check("mid_rst_zero", 32'(bus.rd_zero), 32'd1);
            check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
            check("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
            repeat (4) tick();
            check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
            check("mid_rst_no_late", 32'(bus.data_out), 32'd0);
            $display("reset during read checked");
        end
        do_write(16'h0044, 16'hBEEF, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            int op;
            ra = {8'h00, 4'h4, 4'($urandom_range(0, 15))};
            rd = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) do_write(ra, rd, 1'($urandom_range(0, 1)));
            else do_read(ra, op == 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
